// File: rtl/calc_seq_ctrl.sv
// Keypad-to-ALU sequencing controller: builds operand A, operator and operand B from scanner
// events, runs one start/done ALU transaction per computation and holds the display value.
module calc_seq_ctrl #(
  parameter int unsigned W      = 16,
  parameter int unsigned MAXDIG = 4
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         numberflag,
  input  logic [3:0]   key_value,
  input  logic         opflag,
  input  logic [2:0]   operator,
  input  logic         equal,
  output logic         alu_start,
  output logic [2:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic         alu_done,
  input  logic [W-1:0] alu_result,
  input  logic         alu_err,
  output logic [W-1:0] disp_value,
  output logic         disp_err,
  output logic         busy,
  output logic [2:0]   state
);

  localparam int unsigned CntW = $clog2(MAXDIG + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAXDIG);
  localparam logic [CntW-1:0] OneCnt = CntW'(1);

  typedef enum logic [2:0] {
    StEnterA  = 3'd0,
    StGotOp   = 3'd1,
    StEnterB  = 3'd2,
    StWaitAlu = 3'd3,
    StShow    = 3'd4
  } state_e;

  // Flag bit order: [0] digit, [1] operator, [2] equal.
  logic [2:0] sync1_q, sync2_q, seen_q, evt_q;
  logic [3:0] key_q;
  logic [2:0] oper_q;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      seen_q  <= '0;
      evt_q   <= '0;
      key_q   <= '0;
      oper_q  <= '0;
    end else begin
      sync1_q <= {equal, opflag, numberflag};
      sync2_q <= sync1_q;
      seen_q  <= sync2_q;
      evt_q   <= sync2_q & ~seen_q;
      // Data lines are stable while their flag is high, so capture them with the edge.
      if (sync2_q[0] && !seen_q[0]) key_q <= key_value;
      if (sync2_q[1] && !seen_q[1]) oper_q <= operator;
    end
  end

  logic eq_ev, op_ev, dig_ev, dig_ok;
  assign eq_ev  = evt_q[2];
  assign op_ev  = evt_q[1] & ~evt_q[2];
  assign dig_ev = evt_q[0] & ~evt_q[1] & ~evt_q[2];
  assign dig_ok = (key_q <= 4'd9);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
  logic [CntW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [2:0]      op_q, op_d, pend_q, pend_d, alu_op_q, alu_op_d;
  logic            err_q, err_d, start_q, start_d;
  logic [W-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;

  logic [W-1:0] key_ext, a_acc, b_acc;
  assign key_ext = W'(key_q);
  assign a_acc   = a_q * W'(10) + key_ext;
  assign b_acc   = b_q * W'(10) + key_ext;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    disp_d   = disp_q;
    a_cnt_d  = a_cnt_q;
    b_cnt_d  = b_cnt_q;
    op_d     = op_q;
    pend_d   = pend_q;
    err_d    = err_q;
    start_d  = 1'b0;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    unique case (state_q)
      StEnterA: begin
        if (op_ev) begin
          op_d    = oper_q;
          state_d = StGotOp;
        end else if (dig_ev && dig_ok && (a_cnt_q < MaxCnt)) begin
          a_d     = a_acc;
          a_cnt_d = a_cnt_q + OneCnt;
          disp_d  = a_acc;
        end
      end
      StGotOp: begin
        if (op_ev) begin
          op_d = oper_q;
        end else if (dig_ev && dig_ok) begin
          b_d     = key_ext;
          b_cnt_d = OneCnt;
          disp_d  = key_ext;
          state_d = StEnterB;
        end
      end
      StEnterB: begin
        if (eq_ev || op_ev) begin
          start_d  = 1'b1;
          alu_a_d  = a_q;
          alu_b_d  = b_q;
          alu_op_d = op_q;
          // A zero pending_op means "stop in SHOW"; a real operator chains the next step.
          pend_d   = eq_ev ? 3'd0 : oper_q;
          state_d  = StWaitAlu;
        end else if (dig_ev && dig_ok && (b_cnt_q < MaxCnt)) begin
          b_d     = b_acc;
          b_cnt_d = b_cnt_q + OneCnt;
          disp_d  = b_acc;
        end
      end
      StWaitAlu: begin
        if (alu_done) begin
          if (alu_err) begin
            err_d   = 1'b1;
            disp_d  = '0;
            a_d     = '0;
            state_d = StShow;
          end else begin
            res_d  = alu_result;
            disp_d = alu_result;
            if (pend_q != 3'd0) begin
              a_d     = alu_result;
              op_d    = pend_q;
              state_d = StGotOp;
            end else begin
              state_d = StShow;
            end
          end
        end
      end
      StShow: begin
        if (op_ev) begin
          if (!err_q) begin
            a_d     = res_q;
            op_d    = oper_q;
            state_d = StGotOp;
          end
        end else if (dig_ev && dig_ok) begin
          err_d   = 1'b0;
          a_d     = key_ext;
          a_cnt_d = OneCnt;
          disp_d  = key_ext;
          state_d = StEnterA;
        end
      end
      default: state_d = StEnterA;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q  <= StEnterA;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      disp_q   <= '0;
      a_cnt_q  <= '0;
      b_cnt_q  <= '0;
      op_q     <= '0;
      pend_q   <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      disp_q   <= disp_d;
      a_cnt_q  <= a_cnt_d;
      b_cnt_q  <= b_cnt_d;
      op_q     <= op_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      start_q  <= start_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
    end
  end

  assign alu_start  = start_q;
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign disp_value = disp_q;
  assign disp_err   = err_q;
  assign busy       = (state_q == StWaitAlu);
  assign state      = state_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Randomized scoreboard bench for calc_seq_ctrl: a key-press-level calculator model predicts
// ALU requests and displayed results; monitors pop and compare when the DUT presents them.
module tb_calc_seq_ctrl;
  localparam int unsigned W      = 16;
  localparam int unsigned MAXDIG = 4;

  logic         clk = 1'b0;
  logic         RST;
  logic         numberflag, opflag, equal;
  logic [3:0]   key_value;
  logic [2:0]   operator;
  logic         alu_start;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_result, disp_value;
  logic         alu_done, alu_err, disp_err, busy;
  logic [2:0]   state;

  always #5 clk = ~clk;

  calc_seq_ctrl #(.W(W), .MAXDIG(MAXDIG)) dut (
    .clk(clk), .RST(RST), .numberflag(numberflag), .key_value(key_value), .opflag(opflag),
    .operator(operator), .equal(equal), .alu_start(alu_start), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done), .alu_result(alu_result),
    .alu_err(alu_err), .disp_value(disp_value), .disp_err(disp_err), .busy(busy),
    .state(state)
  );

  int errors = 0;
  int checks = 0;

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [2:0] op; } txn_t;
  typedef struct { logic [W-1:0] v; logic e; logic [2:0] st; } disp_t;
  txn_t  exp_txn[$];
  disp_t exp_disp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void alu_calc(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] r,
                                   output logic e);
    int unsigned x, y, t;
    e = 1'b0;
    r = '0;
    case (op)
      3'd1: r = W'(a + b);
      3'd2: r = W'(a - b);
      3'd3: r = W'(a * b);
      3'd4: if (b == 0) e = 1'b1; else r = a / b;
      3'd5: begin
        x = a; y = b;
        while (y != 0) begin t = x % y; x = y; y = t; end
        r = W'(x);
      end
      default: r = '0;
    endcase
  endfunction

  // Calculator model at key-press granularity.
  typedef enum int {MEntA, MGotOp, MEntB, MShow} mph_e;
  mph_e         m_ph;
  logic [W-1:0] m_a, m_b, m_last, m_disp;
  int unsigned  m_cnt;
  logic [2:0]   m_op;
  logic         m_err;

  function automatic logic [2:0] m_code();
    case (m_ph)
      MEntA:   return 3'd0;
      MGotOp:  return 3'd1;
      MEntB:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic void model_reset();
    m_ph = MEntA; m_a = '0; m_b = '0; m_last = '0; m_disp = '0;
    m_cnt = 0; m_op = '0; m_err = 1'b0;
  endfunction

  function automatic void push_txn();
    txn_t t;
    t.a = m_a; t.b = m_b; t.op = m_op;
    exp_txn.push_back(t);
  endfunction

  function automatic void m_fire(input bit chain, input logic [2:0] nxt);
    logic [W-1:0] r;
    logic         e;
    disp_t        d;
    push_txn();
    alu_calc(m_op, m_a, m_b, r, e);
    if (e) begin
      m_err = 1'b1; m_disp = '0; m_a = '0; m_ph = MShow;
    end else begin
      m_last = r; m_disp = r;
      if (chain) begin m_a = r; m_op = nxt; m_ph = MGotOp; end
      else m_ph = MShow;
    end
    d.v = m_disp; d.e = m_err; d.st = m_code();
    exp_disp.push_back(d);
  endfunction

  function automatic void model_digit(input int unsigned k);
    if (k > 9) return;
    case (m_ph)
      MEntA: if (m_cnt < MAXDIG) begin
        m_a = W'(m_a * 10 + k); m_cnt++; m_disp = m_a;
      end
      MGotOp: begin m_b = W'(k); m_cnt = 1; m_disp = m_b; m_ph = MEntB; end
      MEntB: if (m_cnt < MAXDIG) begin
        m_b = W'(m_b * 10 + k); m_cnt++; m_disp = m_b;
      end
      default: begin m_err = 1'b0; m_a = W'(k); m_cnt = 1; m_disp = m_a; m_ph = MEntA; end
    endcase
  endfunction

  function automatic void model_op(input logic [2:0] o);
    case (m_ph)
      MEntA, MGotOp: begin m_op = o; m_ph = MGotOp; end
      MEntB: m_fire(1'b1, o);
      default: if (!m_err) begin m_a = m_last; m_op = o; m_ph = MGotOp; end
    endcase
  endfunction

  function automatic void model_equal();
    if (m_ph == MEntB) m_fire(1'b0, 3'd0);
  endfunction

  // Stimulus
  bit alu_auto = 1'b1;
  int alu_lat_fixed = 0;

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    check("busy_timeout", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input int kind, input logic [3:0] val, input int hold, input bit wt);
    @(negedge clk);
    case (kind)
      0:       begin key_value = val; numberflag = 1'b1; end
      1:       begin operator = val[2:0]; opflag = 1'b1; end
      default: equal = 1'b1;
    endcase
    repeat (hold) @(negedge clk);
    numberflag = 1'b0; opflag = 1'b0; equal = 1'b0;
    repeat (6) @(negedge clk);
    if (wt) wait_idle();
  endtask

  task automatic do_digit(input int unsigned k, input int hold);
    model_digit(k);
    press(0, 4'(k), hold, 1'b1);
  endtask

  task automatic do_op(input logic [2:0] o);
    model_op(o);
    press(1, {1'b0, o}, $urandom_range(2, 12), 1'b1);
  endtask

  task automatic do_eq();
    model_equal();
    press(2, 4'd0, $urandom_range(2, 12), 1'b1);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_disp"}, disp_value, m_disp);
    check({tag, "_err"}, disp_err, m_err);
    check({tag, "_state"}, state, m_code());
  endtask

  task automatic apply_reset();
    @(negedge clk);
    RST = 1'b0;
    repeat (3) @(negedge clk);
    RST = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  // ALU responder
  initial begin
    logic [W-1:0] r;
    logic         e;
    int           lat, nb;
    alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
    forever begin
      @(negedge clk);
      if (RST && alu_start && alu_auto) begin
        lat = (alu_lat_fixed != 0) ? alu_lat_fixed : int'($urandom_range(1, 8));
        alu_calc(alu_op, alu_a, alu_b, r, e);
        nb = busy ? 1 : 0;
        repeat (lat) begin @(negedge clk); if (busy) nb++; end
        alu_done = 1'b1; alu_result = r; alu_err = e;
        @(negedge clk);
        alu_done = 1'b0; alu_err = 1'b0;
        check("busy_fall", busy, 0);
        check("busy_len", nb, lat + 1);
      end
    end
  end

  // Transaction monitor
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (RST && alu_start) begin
        if (exp_txn.size() == 0) begin
          checks++; errors++;
          $display("FAIL txn_unexpected: got a=%0d b=%0d op=%0d required none", alu_a, alu_b,
                   alu_op);
        end else begin
          t = exp_txn.pop_front();
          check("alu_a", alu_a, t.a);
          check("alu_b", alu_b, t.b);
          check("alu_op", alu_op, t.op);
        end
      end
    end
  end

  // Result monitor: fires when busy drops out of reset context
  initial begin
    disp_t d;
    bit    bp = 1'b0;
    forever begin
      @(negedge clk);
      if (!RST) bp = 1'b0;
      else begin
        if (bp && !busy) begin
          if (exp_disp.size() == 0) begin
            checks++; errors++;
            $display("FAIL result_unexpected: got disp=%0d required none", disp_value);
          end else begin
            d = exp_disp.pop_front();
            check("res_disp", disp_value, d.v);
            check("res_err", disp_err, d.e);
            check("res_state", state, d.st);
          end
        end
        bp = busy;
      end
    end
  end

  initial begin
    RST = 1'b0; numberflag = 1'b0; opflag = 1'b0; equal = 1'b0;
    key_value = '0; operator = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_start", alu_start, 0);
    check("rst_op", alu_op, 0);
    check("rst_a", alu_a, 0);
    check("rst_b", alu_b, 0);
    check("rst_disp", disp_value, 0);
    check("rst_err", disp_err, 0);
    check("rst_busy", busy, 0);
    RST = 1'b1;
    repeat (2) @(negedge clk);

    // Basic add with a fixed 5-cycle ALU
    alu_lat_fixed = 5;
    do_digit(1, 3); do_digit(2, 3); do_op(3'd1); do_digit(3, 3); do_digit(4, 3); do_eq();
    check_model("add");
    alu_lat_fixed = 0;

    // Long hold gives a single accumulation
    apply_reset();
    do_digit(7, 200);
    check_model("hold");

    // Fifth digit ignored
    apply_reset();
    for (int i = 1; i <= 5; i++) do_digit(i, 4);
    check_model("ovf");

    // Divide by zero, ignored operator, then recovery by digit
    apply_reset();
    do_digit(8, 3); do_op(3'd4); do_digit(0, 3); do_eq();
    check_model("div0");
    do_op(3'd1);
    check_model("div0_op");
    do_digit(7, 3);
    check_model("div0_dig");

    // Chaining
    apply_reset();
    do_digit(2, 3); do_op(3'd1); do_digit(3, 3); do_op(3'd3);
    check_model("chain1");
    do_digit(4, 3); do_eq();
    check_model("chain2");

    // Random key sequences
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 99);
      if (k < 55) do_digit($urandom_range(0, 11), $urandom_range(2, 12));
      else if (k < 82) do_op(3'($urandom_range(1, 5)));
      else do_eq();
      check_model("rand");
    end

    // Reset while waiting on the ALU, then a stale alu_done
    apply_reset();
    alu_auto = 1'b0;
    do_digit(9, 3); do_op(3'd1); do_digit(1, 3);
    push_txn();
    press(2, 4'd0, 3, 1'b0);
    check("mid_busy", busy, 1);
    @(negedge clk);
    #2 RST = 1'b0;
    #1;
    check("mid_state", state, 0);
    check("mid_start", alu_start, 0);
    check("mid_op", alu_op, 0);
    check("mid_a", alu_a, 0);
    check("mid_b", alu_b, 0);
    check("mid_disp", disp_value, 0);
    check("mid_err", disp_err, 0);
    check("mid_busy_rst", busy, 0);
    repeat (2) @(negedge clk);
    RST = 1'b1;
    model_reset();
    @(negedge clk);
    alu_done = 1'b1; alu_result = 16'd123;
    @(negedge clk);
    alu_done = 1'b0;
    repeat (2) @(negedge clk);
    check("late_state", state, 0);
    check("late_disp", disp_value, 0);

    check("txn_left", exp_txn.size(), 0);
    check("res_left", exp_disp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
# calc_seq_ctrl

- Sequencing controller between the keypad scanner and the shared arithmetic unit.
- Turns scanner event flags (digit, operator, equal) into operand A, operator and operand B.
- Issues one start/done transaction per computation to the ALU and holds the value to be shown on the display.
- Supports left-to-right operator chaining and divide-error reporting.

## Interface
Parameters:
- W, 16, operand/result width in bits (unsigned)
- MAXDIG, 4, maximum decimal digits accepted per operand

Ports:
- clk  input  1  system clock
- RST  input  1  reset, asynchronous, active-low
- numberflag  input  1  scanner digit-valid level; held high until key release
- key_value  input  4  digit 0..9; stable while numberflag high
- opflag  input  1  scanner operator-valid level; held until release
- operator  input  3  operator code: 001 add, 010 sub, 011 mul, 100 div, 101 gcd; stable while opflag high
- equal  input  1  scanner equal level; held until release
- alu_start  output  1  one-cycle request pulse
- alu_op  output  3  operator for current transaction
- alu_a  output  W  operand A
- alu_b  output  W  operand B
- alu_done  input  1  one-cycle completion pulse
- alu_result  input  W  result; valid with alu_done
- alu_err  input  1  error (divide by zero); valid with alu_done
- disp_value  output  W  value for the display driver
- disp_err  output  1  error indicator
- busy  output  1  high while a transaction is outstanding
- state  output  3  current FSM state code (debug)

## Operation
- numberflag, opflag and equal come from the scanner's gated clock domain and are synchronized with two flops each.
- An event is the rising edge of a synchronized flag; one event per key press regardless of hold time.
- key_value and operator are sampled in the cycle the event is detected.
- Simultaneous events: priority equal > operator > digit; lower-priority events in the same cycle are dropped.
- Digit entry: acc <= acc*10 + key_value, truncated to W bits.
  - Digit count tracked per operand; digits beyond MAXDIG are ignored.
  - Values of key_value above 9 are ignored.
- States: ENTER_A=0, GOT_OP=1, ENTER_B=2, WAIT_ALU=3, SHOW=4.
- ENTER_A:
  - digit: accumulate into A; disp_value=A.
  - operator: latch op, go to GOT_OP.
  - equal: ignored.
- GOT_OP:
  - digit: B=digit, count=1, go to ENTER_B.
  - operator: replaces the latched op.
  - equal: ignored.
- ENTER_B:
  - digit: accumulate into B; disp_value=B.
  - equal: pulse alu_start, clear pending_op, go to WAIT_ALU.
  - operator: pulse alu_start, store it as pending_op, go to WAIT_ALU.
- WAIT_ALU:
  - All key events are dropped.
  - On alu_done, no error, pending_op set: A=alu_result, op=pending_op, disp_value=alu_result, go to GOT_OP.
  - On alu_done, no error, pending_op clear: disp_value=alu_result, go to SHOW.
  - On alu_done with alu_err: disp_err=1, disp_value=0, A=0, go to SHOW.
- SHOW:
  - digit: clear disp_err, A=digit, count=1, go to ENTER_A.
  - operator with disp_err=0: A=last result, latch op, go to GOT_OP.
  - operator with disp_err=1: ignored.
  - equal: ignored.
- alu_a, alu_b and alu_op are registered; they are loaded on the alu_start cycle and held until the next start.
- alu_done outside WAIT_ALU is ignored.

## Timing
- Reset (asynchronous, RST low):
  - state=ENTER_A, A=B=0, counts=0, pending_op=0, synchronizers=0.
  - alu_start=0, alu_op=000, alu_a=0, alu_b=0, disp_value=0, disp_err=0, busy=0.
- Key latency: a flag rising before clk edge n produces its register update at edge n+3 (two synchronizer stages plus the edge register).
- alu_start is high for exactly one cycle, on the same edge that enters WAIT_ALU; busy rises on that edge.
- alu_done is sampled at edge k; result/state updates and busy fall at edge k.
- A new alu_start is no earlier than edge k+1.
- No timeout: the block waits indefinitely for alu_done.
- RST low mid-transaction aborts immediately.
- An alu_done arriving after reset releases is ignored, because state is then ENTER_A.

## Test plan
- Basic add: keys 1,2,op001,3,4,= with an ALU model returning 46 after 5 cycles -> a single alu_start with alu_a=12, alu_b=34, alu_op=001; disp_value=46; state=SHOW; busy high for exactly the wait.
- Hold/bounce: numberflag held high 200 cycles with key_value=7 -> A=7, exactly one accumulation.
- Overflow digits: MAXDIG=4, keys 1,2,3,4,5 -> disp_value=1234; fifth digit ignored.
- Divide error: 8,op100,0,= with the model asserting alu_err -> disp_err=1, disp_value=0.
  - An operator in SHOW is then ignored.
  - Digit 7 clears disp_err and gives disp_value=7.
- Chaining: 2,op001,3,op011,4,= -> first transaction (2,3,001) returns 5, then state GOT_OP with disp_value=5; second transaction (5,4,011) returns 20, disp_value=20.
- Reset mid-transaction: RST low for 2 cycles while in WAIT_ALU.
  - All outputs return to their reset values asynchronously.
  - A late alu_done leaves state=ENTER_A and disp_value=0.
